dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (256 x 32, write on negedge CLK when opcode == `SDW, combinational read) between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the debug/loader port, used for preload and dump.
- Fixed priority to port 0, with a starvation counter that forces a port-1 grant.
- One registered command stage in front of the memory; read data is returned registered with a valid pulse.

Parameters:
- DEPTH, 256: number of words in the data memory; addresses >= DEPTH are out of range.
- STARVE_MAX, 4: consecutive cycles port 1 may be denied while requesting before it is forced to win.
- IDLE_OP, 6'b111111: opcode driven to the memory when no write is issued; must differ from `SDW.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- req0  in  1  port 0 request
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  32  port 0 word address
- wdata0  in  32  port 0 write data
- gnt0  out  1  port 0 accepted this cycle (combinational)
- stall0  out  1  req0 & ~gnt0; pipeline freeze
- rdata0  out  32  port 0 read data
- rvalid0  out  1  rdata0 valid (1-cycle pulse)
- req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same as port 0, for port 1
- err1  out  1  port 1 out-of-range access (1-cycle pulse, aligned with rvalid1)
- mem_addr  out  32  to memory addr
- mem_data  out  32  to memory data
- mem_op  out  6  to memory opcode: `SDW or IDLE_OP
- mem_rdata  in  32  from memory out

Behaviour:
- Reset (sync, RST high at posedge): command register cleared (cmd_valid=0, mem_op=IDLE_OP, mem_addr=0, mem_data=0). Also clears rdata0/1=0, rvalid0/1=0, err1=0, starve_cnt=0. gnt0/gnt1 forced 0 while RST is high.
- Arbitration (combinational, cycle k):
  - If only one port requests, it wins.
  - If both request, port 0 wins unless starve_cnt == STARVE_MAX, in which case port 1 wins.
  - Exactly one of gnt0/gnt1 is high when any request is present and RST is low.
- Requester rule: fields must be held stable while req is high and gnt is low. A request is consumed at the posedge where gnt is high. Dropping req before gnt is legal (request withdrawn).
- starve_cnt: at each posedge, +1 if req1 & ~gnt1 (saturating at STARVE_MAX); cleared to 0 when gnt1 or ~req1.
- Command stage: at the posedge ending cycle k, the winner's addr/data/we/port id latch into the command register. During cycle k+1:
  - mem_addr and mem_data come from the register.
  - mem_op = `SDW if the command is a valid, in-range write; else IDLE_OP.
  - The memory write occurs at the negedge inside cycle k+1.
- Read return: at the posedge ending cycle k+1, a valid read command captures mem_rdata into rdataN and pulses rvalidN for cycle k+2. Latency from grant to data visible = 2 cycles.
  - Writes also pulse rvalidN as an acknowledgement; rdataN is unchanged on a write.
  - rdataN holds its value between pulses.
- Throughput: one access per cycle, back-to-back from either port. No bypass between a write in k+1 and a read granted in k+1: the read executes in k+2 and sees the written value, because the negedge write precedes the next read.
- Out of range (addr >= DEPTH):
  - No write is issued (mem_op=IDLE_OP); read returns 0.
  - rvalid still pulses.
  - err1 pulses for port 1. Port 0 has no error output; it sees 0 data.
- Reset mid-operation: an in-flight command is dropped with no write issued, no rvalid and no err.

Test Plan:
- Reset, then port 0 write addr 5 data 0xDEAD, then read addr 5 -> gnt0 high each request cycle; mem_op=`SDW one cycle; rvalid0 2 cycles after the read grant with rdata0=0xDEAD.
- Port 1 reads addr 0..3 back-to-back, starting from the preloaded memory (values 6..9) -> rvalid1 on 4 consecutive cycles, rdata1 = 6,7,8,9.
- req0 and req1 held continuously, STARVE_MAX=4 -> gnt0 for 4 cycles, then gnt1 for 1 cycle, repeating; stall0 high exactly in the gnt1 cycles.
- Port 1 write addr 300 data 0x1234 -> mem_op stays IDLE_OP, rvalid1 and err1 pulse together, memory unchanged.
- Port 0 write granted, RST asserted the next cycle -> no `SDW issued, no rvalid0, target word unchanged, all outputs at reset values.
- Port 0 write addr 7 = 0x55 granted at cycle k, port 1 read addr 7 granted at k+1 -> rdata1 = 0x55 in cycle k+3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MEM
// stage (port 0) and the debug/loader port (port 1).
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   req0/we0/addr0/wdata0         port 0 request, write enable, word address, write data
//   gnt0, stall0                  port 0 accepted this cycle / pipeline freeze
//   rdata0, rvalid0               port 0 registered read data and completion pulse
//   req1/we1/addr1/wdata1         port 1 request fields
//   gnt1, rdata1, rvalid1, err1   port 1 grant, read data, completion, out-of-range pulse
//   mem_addr, mem_data, mem_op    command to memory (write on negedge when mem_op == SDW_OP)
//   mem_rdata                     combinational read data from memory
//
// Port 0 has fixed priority; port 1 is forced through after STARVE_MAX
// consecutive denied cycles. Grant-to-data latency is two cycles.
module dmem_arbiter #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned STARVE_MAX = 4,
   parameter logic [5:0]  IDLE_OP    = 6'b111111,
   parameter logic [5:0]  SDW_OP     = 6'b101011
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        gnt0,
   output logic        stall0,
   output logic [31:0] rdata0,
   output logic        rvalid0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt1,
   output logic [31:0] rdata1,
   output logic        rvalid1,
   output logic        err1,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic [5:0]  mem_op,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;
   logic          starved;

   logic          cmd_valid;
   logic          cmd_we;
   logic          cmd_port;
   logic          cmd_inr;

   logic          any_gnt;
   logic          win_we;
   logic [31:0]   win_addr;
   logic [31:0]   win_data;

   assign starved = (starve_cnt == CW'(STARVE_MAX));

   assign gnt1    = ~RST & req1 & (~req0 | starved);
   assign gnt0    = ~RST & req0 & ~gnt1;
   assign stall0  = req0 & ~gnt0;
   assign any_gnt = gnt0 | gnt1;

   assign win_we   = gnt1 ? we1    : we0;
   assign win_addr = gnt1 ? addr1  : addr0;
   assign win_data = gnt1 ? wdata1 : wdata0;

   // Gated by RST so a reset raised in the cycle after a write grant
   // suppresses the negedge write of the in-flight command.
   assign mem_op = (cmd_valid & cmd_we & cmd_inr & ~RST) ? SDW_OP : IDLE_OP;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cmd_valid  <= 1'b0;
         cmd_we     <= 1'b0;
         cmd_port   <= 1'b0;
         cmd_inr    <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         rdata0     <= '0;
         rdata1     <= '0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         err1       <= 1'b0;
         starve_cnt <= '0;
      end else begin
         cmd_valid <= any_gnt;
         if (any_gnt) begin
            cmd_we   <= win_we;
            cmd_port <= gnt1;
            cmd_inr  <= (win_addr < 32'(DEPTH));
            mem_addr <= win_addr;
            mem_data <= win_data;
         end

         rvalid0 <= cmd_valid & ~cmd_port;
         rvalid1 <= cmd_valid &  cmd_port;
         err1    <= cmd_valid &  cmd_port & ~cmd_inr;

         if (cmd_valid & ~cmd_we & ~cmd_port)
            rdata0 <= cmd_inr ? mem_rdata : '0;
         if (cmd_valid & ~cmd_we & cmd_port)
            rdata1 <= cmd_inr ? mem_rdata : '0;

         if (req1 & ~gnt1) begin
            if (!starved)
               starve_cnt <= starve_cnt + CW'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int unsigned DEPTH      = 256;
   localparam int unsigned STARVE_MAX = 4;
   localparam logic [5:0]  IDLE       = 6'b111111;
   localparam logic [5:0]  SDW        = 6'b101011;

   logic        CLK = 1'b0;
   logic        rst;
   logic        r0, w0, r1, w1;
   logic [31:0] a0, d0, a1, d1;
   logic        gnt0, stall0, rvalid0, gnt1, rvalid1, err1;
   logic [31:0] rdata0, rdata1, mem_addr, mem_data, mem_rdata;
   logic [5:0]  mem_op;

   always #5 CLK = ~CLK;

   dmem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .IDLE_OP(IDLE), .SDW_OP(SDW)) dut (
      .CLK(CLK), .RST(rst),
      .req0(r0), .we0(w0), .addr0(a0), .wdata0(d0),
      .gnt0(gnt0), .stall0(stall0), .rdata0(rdata0), .rvalid0(rvalid0),
      .req1(r1), .we1(w1), .addr1(a1), .wdata1(d1),
      .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1), .err1(err1),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_op(mem_op), .mem_rdata(mem_rdata)
   );

   // Data memory: negedge write, combinational read.
   logic [31:0] mem [0:255];
   always @(negedge CLK) if (mem_op == SDW) mem[mem_addr[7:0]] <= mem_data;
   assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

   // Reference model: memory image, starvation count, one in-flight
   // access and the currently presented responses.
   logic [31:0] ref_mem [0:255];
   int          starve;
   bit          p_v, p_port, p_we;
   logic [31:0] p_a, p_d;
   bit          o_v0, o_v1, o_err;
   logic [31:0] o_rd0, o_rd1;
   bit          mg0, mg1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      starve = 0; p_v = 0; o_v0 = 0; o_v1 = 0; o_err = 0; o_rd0 = '0; o_rd1 = '0;
   endtask

   // One clock cycle: check this cycle's outputs, then advance the model.
   task automatic step();
      bit g0, g1, inr, cur_r1;
      logic [5:0]  eop;
      logic [31:0] val;
      #1;
      if (rst) begin
         g0 = 0; g1 = 0;
      end else begin
         g1 = r1 && (!r0 || starve == STARVE_MAX);
         g0 = r0 && !g1;
      end
      mg0 = g0; mg1 = g1; cur_r1 = r1;
      eop = (!rst && p_v && p_we && p_a < DEPTH) ? SDW : IDLE;
      chk("gnt0", {31'b0, gnt0}, {31'b0, g0});
      chk("gnt1", {31'b0, gnt1}, {31'b0, g1});
      chk("stall0", {31'b0, stall0}, {31'b0, r0 & ~g0});
      chk("mem_op", {26'b0, mem_op}, {26'b0, eop});
      if (eop == SDW) begin
         chk("mem_addr", mem_addr, p_a);
         chk("mem_data", mem_data, p_d);
      end
      chk("rvalid0", {31'b0, rvalid0}, {31'b0, o_v0});
      chk("rdata0", rdata0, o_rd0);
      chk("rvalid1", {31'b0, rvalid1}, {31'b0, o_v1});
      chk("rdata1", rdata1, o_rd1);
      chk("err1", {31'b0, err1}, {31'b0, o_err});
      @(posedge CLK);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         o_v0 = 0; o_v1 = 0; o_err = 0;
         if (p_v) begin
            inr = (p_a < DEPTH);
            if (p_we) begin
               if (inr) ref_mem[p_a[7:0]] = p_d;
            end else begin
               val = inr ? ref_mem[p_a[7:0]] : 32'h0;
               if (p_port) o_rd1 = val; else o_rd0 = val;
            end
            if (p_port) begin o_v1 = 1; o_err = !inr; end
            else o_v0 = 1;
         end
         p_v = g0 || g1;
         if (p_v) begin
            p_port = g1;
            p_we   = g1 ? w1 : w0;
            p_a    = g1 ? a1 : a0;
            p_d    = g1 ? d1 : d0;
         end
         if (cur_r1 && !g1) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
         else starve = 0;
      end
   endtask

   task automatic set0(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      r0 = r; w0 = w; a0 = a; d0 = d;
   endtask

   task automatic set1(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
      r1 = r; w1 = w; a1 = a; d1 = d;
   endtask

   bit          pend [2];
   bit          pw   [2];
   logic [31:0] pa   [2];
   logic [31:0] pd   [2];

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) < 8) return 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) return 32'($urandom_range(256, 300));
      return 32'hFFFF_FFF0;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'(i + 6);
         ref_mem[i] = 32'(i + 6);
      end
      rst = 1'b1;
      set0(0, 0, '0, '0);
      set1(0, 0, '0, '0);
      repeat (2) @(posedge CLK);
      #1;
      model_reset();
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_data", mem_data, 32'h0);
      rst = 1'b0;
      step();

      // port 0 write then read back
      set0(1, 1, 32'd5, 32'hDEAD); step();
      set0(1, 0, 32'd5, 32'h0);    step();
      set0(0, 0, '0, '0);          repeat (3) step();
      chk("p0_readback", rdata0, 32'hDEAD);

      // port 1 back-to-back reads of preloaded words
      for (int i = 0; i < 4; i++) begin
         set1(1, 0, 32'(i), '0); step();
      end
      set1(0, 0, '0, '0); repeat (3) step();
      chk("p1_last_read", rdata1, 32'd9);

      // both ports held: starvation forcing
      set0(1, 0, 32'd10, '0);
      set1(1, 0, 32'd11, '0);
      repeat (12) step();
      set0(0, 0, '0, '0); set1(0, 0, '0, '0); repeat (3) step();

      // port 1 out-of-range write
      set1(1, 1, 32'd300, 32'h1234); step();
      set1(0, 0, '0, '0); repeat (3) step();

      // write granted, reset in the following cycle
      set0(1, 1, 32'd9, 32'h77); step();
      set0(0, 0, '0, '0); rst = 1'b1; step();
      rst = 1'b0; repeat (3) step();

      // write from port 0 then read from port 1 one cycle later
      set0(1, 1, 32'd7, 32'h55); step();
      set0(0, 0, '0, '0); set1(1, 0, 32'd7, '0); step();
      set1(0, 0, '0, '0); step();
      step();
      chk("p1_sees_p0_write", rdata1, 32'h55);
      repeat (2) step();

      // randomized traffic obeying the hold-until-granted rule
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (pend[p] && $urandom_range(0, 99) < 8) pend[p] = 0;
            if (!pend[p] && $urandom_range(0, 99) < 60) begin
               pend[p] = 1;
               pw[p] = 1'($urandom_range(0, 1));
               pa[p] = rand_addr();
               pd[p] = $urandom;
            end
         end
         rst = ($urandom_range(0, 99) < 2);
         set0(pend[0], pw[0], pa[0], pd[0]);
         set1(pend[1], pw[1], pa[1], pd[1]);
         step();
         if (mg0) pend[0] = 0;
         if (mg1) pend[1] = 0;
      end
      rst = 1'b0;
      set0(0, 0, '0, '0); set1(0, 0, '0, '0);
      repeat (3) step();

      for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
